optical_flow_frame_loader: RTL and testbench

Upstream feeder for the optical-flow HLS accelerator. It accepts a 32-bit pixel stream, stores whole frames in two ping-pong banks, and serves the accelerator's `img` and `prev` read ports from them. It drives the accelerator's `ap_ctrl_hs` start handshake once both the current and previous frames are resident. When the accelerator finishes, it swaps the bank roles so the current frame becomes the next `prev`.

---
 rtl/optical_flow_pkg.sv | 14 +
 rtl/of_frame_bank.sv | 38 +++
 rtl/optical_flow_frame_loader.sv | 157 +++++++++++++++
 tb/tb_optical_flow_frame_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/optical_flow_pkg.sv
// rtl/optical_flow_pkg.sv - shared defaults and state type for the optical-flow frame loader
package optical_flow_pkg;

    localparam int OF_DATA_W      = 32;
    localparam int OF_ADDR_W      = 10;
    localparam int OF_FRAME_WORDS = 1024;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2
    } loader_state_e;

endpackage

// File: rtl/of_frame_bank.sv
// rtl/of_frame_bank.sv - one frame bank: single write port, registered read port with enable
module of_frame_bank
    import optical_flow_pkg::*;
#(
    parameter int DATA_W = OF_DATA_W,
    parameter int ADDR_W = OF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] rdata_q;

    // Array contents deliberately survive reset; only the output register clears.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/optical_flow_frame_loader.sv
// rtl/optical_flow_frame_loader.sv - ping-pong frame store and ap_ctrl_hs sequencer for the optical-flow accelerator
module optical_flow_frame_loader
    import optical_flow_pkg::*;
#(
    parameter int DATA_W      = OF_DATA_W,
    parameter int ADDR_W      = OF_ADDR_W,
    parameter int FRAME_WORDS = OF_FRAME_WORDS
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              acc_start,
    input  logic              acc_ready,
    input  logic              acc_done,
    input  logic [ADDR_W-1:0] img_address0,
    input  logic              img_ce0,
    output logic [DATA_W-1:0] img_q0,
    input  logic [ADDR_W-1:0] prev_address0,
    input  logic              prev_ce0,
    output logic [DATA_W-1:0] prev_q0,
    output logic              busy,
    output logic              frame_err,
    output logic [15:0]       frames_done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    loader_state_e     state_q, state_d;
    logic              wr_sel_q, wr_sel_d;
    logic              rd_sel_q, rd_sel_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              prev_valid_q, prev_valid_d;
    logic [15:0]       frames_done_q, frames_done_d;
    logic              frame_err_q, frame_err_d;
    logic              img_src_q, prev_src_q;

    logic              xfer;
    logic              last_word;

    logic              bank_we    [2];
    logic              bank_re    [2];
    logic [ADDR_W-1:0] bank_raddr [2];
    logic [DATA_W-1:0] bank_rdata [2];

    assign in_ready  = (state_q == LOAD);
    assign acc_start = (state_q == START) && !ap_rst;
    assign busy      = (state_q != LOAD);
    assign xfer      = in_valid && in_ready;
    assign last_word = (wr_addr_q == LAST_ADDR);

    always_comb begin
        state_d       = state_q;
        wr_sel_d      = wr_sel_q;
        rd_sel_d      = rd_sel_q;
        wr_addr_d     = wr_addr_q;
        prev_valid_d  = prev_valid_q;
        frames_done_d = frames_done_q;
        frame_err_d   = xfer && (in_last != last_word);
        case (state_q)
            LOAD: begin
                if (xfer) begin
                    if (last_word) begin
                        wr_addr_d = '0;
                        // The very first frame only primes the prev bank.
                        if (!prev_valid_q) begin
                            prev_valid_d = 1'b1;
                            wr_sel_d     = ~wr_sel_q;
                        end else begin
                            rd_sel_d = wr_sel_q;
                            state_d  = START;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + 1'b1;
                    end
                end
            end
            START: begin
                if (acc_ready) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (acc_done) begin
                    // Overwrite the old prev bank; the current img becomes next prev.
                    wr_sel_d      = ~wr_sel_q;
                    frames_done_d = frames_done_q + 16'd1;
                    state_d       = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q       <= LOAD;
            wr_sel_q      <= 1'b0;
            rd_sel_q      <= 1'b0;
            wr_addr_q     <= '0;
            prev_valid_q  <= 1'b0;
            frames_done_q <= '0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_sel_q      <= wr_sel_d;
            rd_sel_q      <= rd_sel_d;
            wr_addr_q     <= wr_addr_d;
            prev_valid_q  <= prev_valid_d;
            frames_done_q <= frames_done_d;
            frame_err_q   <= frame_err_d;
        end
    end

    // Remember which bank produced each port's last read so the mux follows the data, not rd_sel.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            img_src_q  <= 1'b0;
            prev_src_q <= 1'b1;
        end else begin
            if (img_ce0) begin
                img_src_q <= rd_sel_q;
            end
            if (prev_ce0) begin
                prev_src_q <= ~rd_sel_q;
            end
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign bank_we[b]    = xfer && (wr_sel_q == 1'(b));
        assign bank_re[b]    = (rd_sel_q == 1'(b)) ? img_ce0 : prev_ce0;
        assign bank_raddr[b] = (rd_sel_q == 1'(b)) ? img_address0 : prev_address0;

        of_frame_bank #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (ap_clk),
            .rst   (ap_rst),
            .we    (bank_we[b]),
            .waddr (wr_addr_q),
            .wdata (in_data),
            .re    (bank_re[b]),
            .raddr (bank_raddr[b]),
            .rdata (bank_rdata[b])
        );
    end

    assign img_q0      = bank_rdata[img_src_q];
    assign prev_q0     = bank_rdata[prev_src_q];
    assign frame_err   = frame_err_q;
    assign frames_done = frames_done_q;

endmodule

// File: tb/tb_optical_flow_frame_loader.sv
// tb/tb_optical_flow_frame_loader.sv - directed self-checking bench for optical_flow_frame_loader
module tb_optical_flow_frame_loader;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_last;
    logic        acc_start;
    logic        acc_ready;
    logic        acc_done;
    logic [9:0]  img_address0;
    logic        img_ce0;
    logic [31:0] img_q0;
    logic [9:0]  prev_address0;
    logic        prev_ce0;
    logic [31:0] prev_q0;
    logic        busy;
    logic        frame_err;
    logic [15:0] frames_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ap_clk = ~ap_clk;

    optical_flow_frame_loader dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .in_last       (in_last),
        .acc_start     (acc_start),
        .acc_ready     (acc_ready),
        .acc_done      (acc_done),
        .img_address0  (img_address0),
        .img_ce0       (img_ce0),
        .img_q0        (img_q0),
        .prev_address0 (prev_address0),
        .prev_ce0      (prev_ce0),
        .prev_q0       (prev_q0),
        .busy          (busy),
        .frame_err     (frame_err),
        .frames_done   (frames_done)
    );

    always @(posedge ap_clk) begin
        if (acc_start && acc_ready) begin
            assert (!acc_done) else $error("acc_done coincident with acc_ready in START");
        end
    end

    typedef struct {
        logic [9:0]  ia;
        logic        ice;
        logic [9:0]  pa;
        logic        pce;
        logic [31:0] exp_img;
        logic [31:0] exp_prev;
    } rd_vec_t;

    rd_vec_t vecs [6];

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic load_frame(input logic [31:0] base, input int last_idx,
                              output int errs, output int notready);
        errs     = 0;
        notready = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            in_data = base + 32'(i);
            in_last = (i == last_idx);
            if (!in_ready) notready++;
            step();
            if (frame_err) errs++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic read_pair(input logic [9:0] ia, input logic [9:0] pa);
        img_address0  = ia;
        prev_address0 = pa;
        img_ce0       = 1'b1;
        prev_ce0      = 1'b1;
        step();
        img_ce0  = 1'b0;
        prev_ce0 = 1'b0;
    endtask

    initial begin
        int errs;
        int nr;

        vecs[0] = '{ia: 10'd5,    ice: 1'b1, pa: 10'd5,    pce: 1'b1, exp_img: 32'h0001_0005, exp_prev: 32'h0000_0005};
        vecs[1] = '{ia: 10'd0,    ice: 1'b1, pa: 10'd0,    pce: 1'b1, exp_img: 32'h0001_0000, exp_prev: 32'h0000_0000};
        vecs[2] = '{ia: 10'd1023, ice: 1'b1, pa: 10'd1023, pce: 1'b1, exp_img: 32'h0001_03FF, exp_prev: 32'h0000_03FF};
        vecs[3] = '{ia: 10'd7,    ice: 1'b0, pa: 10'd9,    pce: 1'b0, exp_img: 32'h0001_03FF, exp_prev: 32'h0000_03FF};
        vecs[4] = '{ia: 10'd200,  ice: 1'b0, pa: 10'd300,  pce: 1'b1, exp_img: 32'h0001_03FF, exp_prev: 32'h0000_012C};
        vecs[5] = '{ia: 10'd12,   ice: 1'b1, pa: 10'd13,   pce: 1'b0, exp_img: 32'h0001_000C, exp_prev: 32'h0000_012C};

        ap_rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        acc_ready = 1'b0; acc_done = 1'b0;
        img_address0 = '0; img_ce0 = 1'b0; prev_address0 = '0; prev_ce0 = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_acc_start", 32'(acc_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_err", 32'(frame_err), 32'd0);
        chk("rst_frames_done", 32'(frames_done), 32'd0);
        chk("rst_img_q0", img_q0, 32'd0);
        chk("rst_prev_q0", prev_q0, 32'd0);
        ap_rst = 1'b0;

        // First frame only primes prev: no start.
        load_frame(32'h0, 1023, errs, nr);
        chk("f1_frame_err_count", 32'(errs), 32'd0);
        chk("f1_not_ready", 32'(nr), 32'd0);
        chk("f1_acc_start", 32'(acc_start), 32'd0);
        chk("f1_in_ready", 32'(in_ready), 32'd1);

        load_frame(32'h1_0000, 1023, errs, nr);
        chk("f2_frame_err_count", 32'(errs), 32'd0);
        chk("f2_not_ready", 32'(nr), 32'd0);
        chk("f2_in_ready", 32'(in_ready), 32'd0);
        chk("f2_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            acc_ready = (k == 3);
            chk("f2_acc_start_held", 32'(acc_start), 32'd1);
            step();
        end
        acc_ready = 1'b0;
        chk("f2_acc_start_dropped", 32'(acc_start), 32'd0);
        chk("f2_run_busy", 32'(busy), 32'd1);

        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            chk("run_in_ready", 32'(in_ready), 32'd0);
            step();
        end
        in_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            img_address0  = vecs[v].ia;
            img_ce0       = vecs[v].ice;
            prev_address0 = vecs[v].pa;
            prev_ce0      = vecs[v].pce;
            step();
            chk($sformatf("vec%0d_img_q0", v), img_q0, vecs[v].exp_img);
            chk($sformatf("vec%0d_prev_q0", v), prev_q0, vecs[v].exp_prev);
        end
        img_ce0 = 1'b0; prev_ce0 = 1'b0;

        acc_done = 1'b1;
        step();
        acc_done = 1'b0;
        chk("done_in_ready", 32'(in_ready), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_frames_done", 32'(frames_done), 32'd1);

        // Third frame: early in_last at 500, missing in_last at 1023.
        load_frame(32'h2_0000, 500, errs, nr);
        chk("f3_frame_err_count", 32'(errs), 32'd2);
        chk("f3_acc_start", 32'(acc_start), 32'd1);
        read_pair(10'd7, 10'd7);
        chk("f3_img_q0", img_q0, 32'h0002_0007);
        chk("f3_prev_q0", prev_q0, 32'h0001_0007);
        acc_ready = 1'b1;
        step();
        acc_ready = 1'b0;
        chk("f3_run_acc_start", 32'(acc_start), 32'd0);
        chk("f3_run_busy", 32'(busy), 32'd1);

        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        chk("rrun_busy", 32'(busy), 32'd0);
        chk("rrun_acc_start", 32'(acc_start), 32'd0);
        chk("rrun_frames_done", 32'(frames_done), 32'd0);
        chk("rrun_in_ready", 32'(in_ready), 32'd1);

        load_frame(32'h3_0000, 1023, errs, nr);
        chk("f4_acc_start", 32'(acc_start), 32'd0);
        chk("f4_busy", 32'(busy), 32'd0);
        load_frame(32'h4_0000, 1023, errs, nr);
        chk("f5_acc_start", 32'(acc_start), 32'd1);
        read_pair(10'd3, 10'd3);
        chk("f5_img_q0", img_q0, 32'h0004_0003);
        chk("f5_prev_q0", prev_q0, 32'h0003_0003);

        ap_rst = 1'b1;
        #1;
        chk("rstart_acc_start_immediate", 32'(acc_start), 32'd0);
        step();
        ap_rst = 1'b0;
        chk("rstart_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
